// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, counter-width helpers and the majority voter.
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t IDLE   = 3'd0;
  localparam rx_state_t START  = 3'd1;
  localparam rx_state_t DATA   = 3'd2;
  localparam rx_state_t PARITY = 3'd3;
  localparam rx_state_t STOP   = 3'd4;
  localparam rx_state_t STOP2  = 3'd5;
  localparam rx_state_t BREAK  = 3'd6;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  function automatic int bit_cnt_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority sampling, false-start rejection, sticky error flags and a receive FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a falling edge
// START  | timing to mid start bit; high there means glitch
// DATA   | sampling payload bits LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the first stop bit; good frame is pushed
// STOP2  | waiting out the unchecked second stop bit
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 52,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  input  logic                          err_clr
);

  localparam int BCW = baud_cnt_w(CLKS_PER_BIT);
  localparam int BTW = bit_cnt_w(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LOAD  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LOAD = BCW'(CLKS_PER_BIT / 2);
  localparam logic [BTW-1:0] LAST_BIT  = BTW'(DATA_BITS - 1);

  logic [1:0]           sync_ff;
  logic [2:0]           hist;
  rx_state_t            state;
  logic [BCW-1:0]       baud_cnt;
  logic [BTW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_q;
  logic                 par_bad;
  logic                 tick;
  logic                 sampled;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 frame_set;
  logic                 ovr_set;

  // hist[1] sits at the nominal sample point with one neighbour on each side
  assign tick    = (baud_cnt == '0);
  assign sampled = maj3(hist);

`ifdef UART_RX_PARITY_EN
  logic par_exp;
  logic par_set;
  assign par_exp = (^shreg) ^ PARITY_ODD;
  assign par_set = (state == PARITY) && tick && (sampled != par_exp);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff  <= 2'b11;
      hist     <= 3'b111;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      push_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      sync_ff <= {sync_ff[0], serial_in};
      hist    <= {hist[1:0], sync_ff[1]};
      push_q  <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!hist[0]) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (!tick) baud_cnt <= baud_cnt - BCW'(1);
          else if (sampled) state <= IDLE;
          else begin
            state    <= DATA;
            baud_cnt <= BIT_LOAD;
          end
        end
        DATA: begin
          if (!tick) baud_cnt <= baud_cnt - BCW'(1);
          else begin
            shreg    <= {sampled, shreg[DATA_BITS-1:1]};
            baud_cnt <= BIT_LOAD;
            bit_cnt  <= bit_cnt + BTW'(1);
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == LAST_BIT) state <= PARITY;
`else
            if (bit_cnt == LAST_BIT) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!tick) baud_cnt <= baud_cnt - BCW'(1);
          else begin
            par_bad  <= (sampled != par_exp);
            baud_cnt <= BIT_LOAD;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (!tick) baud_cnt <= baud_cnt - BCW'(1);
          else if (sampled) begin
            push_q   <= !par_bad;
            baud_cnt <= BIT_LOAD;
            state    <= (STOP_BITS == 2) ? STOP2 : IDLE;
          end else begin
            state <= BREAK;
          end
        end
        STOP2: begin
          if (!tick) baud_cnt <= baud_cnt - BCW'(1);
          else state <= IDLE;
        end
        BREAK: begin
          if (hist[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_set = (state == STOP) && tick && !sampled;
  assign ovr_set   = push_q && fifo_full && !(rx_ready && rx_valid);

  // a flag being set in the same cycle as err_clr stays set
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_set | (parity_err & ~err_clr);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a frame-level model queues expected bytes; a monitor checks each pop.
`timescale 1ns/10ps
module tb_uart_rx_fifo;
  localparam int CPB   = 52;
  localparam int DB    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          rx_ready;
  logic          err_clr;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic [4:0]    fifo_count;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int cal_l = 0;
  int wn    = 0;
  logic [DB-1:0] exp_q[$];
  bit exp_ferr = 0, exp_ovr = 0, exp_perr = 0;

  always #20.67 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .err_clr    (err_clr)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // monitor: inputs change on negedge, so +5 ns sees the values the next posedge will use
  initial forever begin
    @(negedge clk);
    #5;
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
    end
  end

  task automatic line_bit(input logic v);
    serial_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    serial_in = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  // frame-level reference: a good frame enters the FIFO unless it is full with no pop in that cycle
  task automatic model_frame(input logic [DB-1:0] d, input logic stop_v, input bit perr, input bit coincide);
    if (!stop_v) exp_ferr = 1;
    if (perr) exp_perr = 1;
    if (stop_v && !perr) begin
      if (exp_q.size() < DEPTH || coincide) exp_q.push_back(d);
      else exp_ovr = 1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input bit par_flip, input bit coincide);
    bit perr;
    perr = 0;
    line_bit(1'b0);
    for (int i = 0; i < DB; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit((^d) ^ par_flip);
    perr = par_flip;
`endif
    model_frame(d, stop_v, perr, coincide);
    line_bit(stop_v);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, int'(fifo_count), exp_q.size());
    check({tag, "_frame_err"}, int'(frame_err), int'(exp_ferr));
    check({tag, "_overrun"}, int'(overrun), int'(exp_ovr));
`ifdef UART_RX_PARITY_EN
    check({tag, "_parity_err"}, int'(parity_err), int'(exp_perr));
`endif
  endtask

  task automatic clr_flags();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
    @(negedge clk);
    check_state("clr");
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("drain_valid", int'(rx_valid), 0);
    check("drain_count", int'(fifo_count), 0);
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check_state("reset");

    // test 1: 0xFD with backpressure; also measure start-edge to rx_valid latency
    rx_ready = 1'b0;
    idle(0); repeat (24) @(negedge clk);
    fork
      send_frame(8'hFD, 1'b1, 1'b0, 1'b0);
      begin
        wn = 0;
        while (wn < 1200) begin
          @(negedge clk);
          wn++;
          if (rx_valid) break;
        end
        cal_l = wn;
      end
    join
    check("latency_in_window", int'(cal_l >= 9 * CPB + CPB / 2 && cal_l <= 9 * CPB + CPB / 2 + 16), 1);
    check("t1_valid", int'(rx_valid), 1);
    check_state("t1");
    drain();

    // test 2: short low glitch is rejected, next frame still received
    serial_in = 1'b0;
    repeat (20) @(negedge clk);
    idle(3);
    check("t2_valid", int'(rx_valid), 0);
    check_state("t2_glitch");
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain();
    check_state("t2");

    // test 3: bad stop bit, line held low, then clear
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (3) line_bit(1'b0);
    idle(2);
    check_state("t3");
    clr_flags();

    // randomized frames: random data, stop validity, backpressure and gaps
    for (int k = 0; k < 12; k++) begin
      logic [DB-1:0] d;
      logic sv;
      d = DB'($urandom_range(0, 255));
      sv = ($urandom_range(0, 4) != 0);
      rx_ready = 1'($urandom_range(0, 1));
      send_frame(d, sv, 1'b0, 1'b0);
      idle($urandom_range(1, 3));
      check_state("rand");
      if ($urandom_range(0, 2) == 0) clr_flags();
    end
    drain();
    clr_flags();

    // test 4: overflow with rx_ready low
    rx_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      send_frame(DB'(k), 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    check_state("t4_full");
    drain();
    clr_flags();

    // test 5: full FIFO, one pop lands on the push cycle of 0x77
    rx_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send_frame(DB'(k * 7 + 3), 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    fork
      send_frame(8'h77, 1'b1, 1'b0, 1'b1);
      begin
        repeat (cal_l - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(1);
    check_state("t5_full");
    check("t5_tail", int'(exp_q[exp_q.size() - 1]), 8'h77);
    drain();

`ifdef UART_RX_PARITY_EN
    // parity (even): good, bad, bad together with bad stop
    rx_ready = 1'b0;
    send_frame(8'h03, 1'b1, 1'b0, 1'b0); idle(2);
    check_state("par_good");
    send_frame(8'h03, 1'b1, 1'b1, 1'b0); idle(2);
    check_state("par_bad");
    send_frame(8'h03, 1'b0, 1'b1, 1'b0); idle(2);
    check_state("par_stop_bad");
    drain();
    clr_flags();
`endif

    // reset mid-frame with data queued and frame_err set
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0); idle(1);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0); idle(1);
    check_state("pre_reset");
    line_bit(1'b0); line_bit(1'b1); line_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
    check("mid_reset_valid", int'(rx_valid), 0);
    check("mid_reset_data", int'(rx_data), 0);
    check_state("mid_reset");
    rst = 1'b0;
    idle(12);
    check_state("post_reset");
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain();
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
